l1_l2_port_arbiter: RTL and testbench
=====================================

// Module: l1_l2_port_arbiter
// PURPOSE
//  Shares the single L2 request port between the Icache refill path and the Dcache
//  refill/write path. Arbitrates round-robin, latches the winner's request and runs
//  one transaction at a time. Routes addrOK and dataOK only to the owner.
//  Sits between Icache/Dcache miss interfaces and the L2cache front end.
// PARAMETERS
//  L1_offset_width  2   log2(words per L1 line); read data = 32<<L1_offset_width bits
// PORTS
//  clk                 in   1    clock
//  rst                 in   1    synchronous reset, active-high
//  i_req               in   1    Icache read request; held until i_addrOK
//  i_addr              in   32   Icache line address
//  i_SUC               in   1    Icache strongly-uncached flag
//  i_addrOK            out  1    request accepted, to Icache
//  i_dataOK            out  1    read data valid, to Icache
//  d_req               in   1    Dcache request; held until d_addrOK
//  d_wr                in   1    0 = read, 1 = write
//  d_addr              in   32   Dcache address
//  d_wdata             in   32   write data
//  d_wstrb             in   4    byte strobes (write)
//  d_size              in   2    access size
//  d_SUC               in   1    Dcache strongly-uncached flag
//  d_addrOK            out  1    request accepted, to Dcache
//  d_dataOK            out  1    read data valid / write done, to Dcache
//  rdata               out  32<<L1_offset_width  read line, shared to both L1s
//  l2_req              out  1    request to L2
//  l2_wr, l2_addr, l2_wdata, l2_wstrb, l2_size, l2_SUC   out  1/32/32/4/2/1  latched fields
//  l2_addrOK           in   1    L2 accepted the request
//  l2_dataOK           in   1    L2 data valid / write complete
//  l2_rdata            in   32<<L1_offset_width  L2 read line
//  busy                out  1    state != IDLE
// BEHAVIOUR
//  - FSM: IDLE -> ADDR -> DATA -> IDLE. One transaction outstanding at a time.
//  - IDLE: if any req, pick a winner and latch its fields into l2_* regs. Set owner.
//    Go to ADDR. With no req, stay in IDLE.
//  - Arbitration: round-robin on a last_owner bit (reset 0 = I).
//    - Both req: grant the one that is not last_owner.
//    - One req: grant it.
//    - last_owner updates at grant.
//  - ADDR: l2_req=1 and latched fields held stable.
//    - On l2_addrOK: pulse owner's *_addrOK in the same cycle (combinational, 1 cycle).
//    - On l2_addrOK: go to DATA.
//    - Without l2_addrOK, stay.
//  - DATA: l2_req=0.
//    - On l2_dataOK: owner's *_dataOK=1 in the same cycle, rdata=l2_rdata (pass-through).
//    - On l2_dataOK: go to IDLE.
//    - Writes also wait for l2_dataOK.
//  - Latency: req seen at edge N -> l2_req high from cycle N+1.
//    - Earliest addrOK to requester is cycle N+1.
//    - One IDLE bubble between back-to-back transactions.
//  - The non-owner never sees addrOK/dataOK.
//  - l2_addrOK outside ADDR is ignored. l2_dataOK outside DATA is ignored.
//  - l2_addrOK and l2_dataOK in the same ADDR cycle: only addrOK is acted on.
//    dataOK is honoured only in DATA.
//  - Requester dropping req while in ADDR: the transaction still completes (fields are latched).
//  - Reset (any state, including mid-transaction):
//    - state=IDLE, last_owner=0.
//    - All outputs 0: l2_req, l2_wr, l2_addr, l2_wdata, l2_wstrb, l2_size, l2_SUC,
//      *_addrOK, *_dataOK, busy.
//    - rdata=0 when not in DATA.
//    - Any in-flight transaction is abandoned.
// TESTING
//  1. i_req=1, i_addr=0x1C000040 alone; L2 addrOK after 2 cycles, dataOK 3 later
//     -> l2_addr=0x1C000040, l2_wr=0, i_addrOK and i_dataOK 1-cycle pulses,
//     -> d_* outputs stay 0, rdata=l2_rdata.
//  2. i_req and d_req together from reset -> D granted first (last_owner=0).
//     -> After its dataOK, one IDLE cycle, then I granted.
//  3. d_req write: addr=0x00001000, wdata=0xDEADBEEF, wstrb=4'b0011
//     -> l2_wr=1, fields exact, held through ADDR.
//     -> d_dataOK only on l2_dataOK.
//  4. Both requesters continuously requesting for 6 transactions -> grants alternate D,I,D,I,D,I.
//  5. rst asserted during DATA -> next cycle state IDLE, all outputs 0.
//     -> A later l2_dataOK produces no *_dataOK.
//  6. Spurious l2_dataOK in IDLE/ADDR and l2_addrOK in DATA -> no requester pulses, no state change.

Source files
------------

// File: rtl/l1_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port between the Icache refill path
// and the Dcache refill/write path; one latched transaction in flight at a time.
module l1_l2_port_arbiter #(
  parameter int unsigned L1_offset_width = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_req,
  input  logic [31:0]                       i_addr,
  input  logic                              i_SUC,
  output logic                              i_addrOK,
  output logic                              i_dataOK,
  input  logic                              d_req,
  input  logic                              d_wr,
  input  logic [31:0]                       d_addr,
  input  logic [31:0]                       d_wdata,
  input  logic [3:0]                        d_wstrb,
  input  logic [1:0]                        d_size,
  input  logic                              d_SUC,
  output logic                              d_addrOK,
  output logic                              d_dataOK,
  output logic [(32<<L1_offset_width)-1:0]  rdata,
  output logic                              l2_req,
  output logic                              l2_wr,
  output logic [31:0]                       l2_addr,
  output logic [31:0]                       l2_wdata,
  output logic [3:0]                        l2_wstrb,
  output logic [1:0]                        l2_size,
  output logic                              l2_SUC,
  input  logic                              l2_addrOK,
  input  logic                              l2_dataOK,
  input  logic [(32<<L1_offset_width)-1:0]  l2_rdata,
  output logic                              busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      r_state, w_state_next;
  logic        r_last_owner;  // 0 = Icache, 1 = Dcache
  logic        r_owner;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_size;
  logic        r_suc;

  logic        w_grant;
  logic        w_grant_d;

  assign w_grant   = (r_state == StIdle) && (i_req || d_req);
  // On contention the requester that did not win last time gets the port.
  assign w_grant_d = d_req && (!i_req || !r_last_owner);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_req || d_req) w_state_next = StAddr;
      StAddr:  if (l2_addrOK)      w_state_next = StData;
      StData:  if (l2_dataOK)      w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= 1'b0;
      r_owner      <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_size       <= '0;
      r_suc        <= 1'b0;
    end else if (w_grant) begin
      r_last_owner <= w_grant_d;
      r_owner      <= w_grant_d;
      if (w_grant_d) begin
        r_wr    <= d_wr;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_wstrb <= d_wstrb;
        r_size  <= d_size;
        r_suc   <= d_SUC;
      end else begin
        // Icache refills are always full-word reads.
        r_wr    <= 1'b0;
        r_addr  <= i_addr;
        r_wdata <= '0;
        r_wstrb <= '0;
        r_size  <= 2'b10;
        r_suc   <= i_SUC;
      end
    end
  end

  always_comb begin
    i_addrOK = 1'b0;
    d_addrOK = 1'b0;
    i_dataOK = 1'b0;
    d_dataOK = 1'b0;
    rdata    = '0;
    l2_req   = (r_state == StAddr);
    busy     = (r_state != StIdle);
    if (r_state == StAddr && l2_addrOK) begin
      i_addrOK = !r_owner;
      d_addrOK = r_owner;
    end
    if (r_state == StData) begin
      rdata = l2_rdata;
      if (l2_dataOK) begin
        i_dataOK = !r_owner;
        d_dataOK = r_owner;
      end
    end
  end

  assign l2_wr    = r_wr;
  assign l2_addr  = r_addr;
  assign l2_wdata = r_wdata;
  assign l2_wstrb = r_wstrb;
  assign l2_size  = r_size;
  assign l2_SUC   = r_suc;

endmodule

// File: tb/tb_l1_l2_port_arbiter.sv
// Directed self-checking bench for l1_l2_port_arbiter; inputs change on the falling
// edge and outputs are sampled 1 time unit later.
module tb_l1_l2_port_arbiter;

  localparam int unsigned Ow = 2;
  localparam int unsigned Lw = 32 << Ow;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_SUC, i_addrOK, i_dataOK;
  logic [31:0]   i_addr;
  logic          d_req, d_wr, d_SUC, d_addrOK, d_dataOK;
  logic [31:0]   d_addr, d_wdata;
  logic [3:0]    d_wstrb;
  logic [1:0]    d_size;
  logic [Lw-1:0] rdata, l2_rdata;
  logic          l2_req, l2_wr, l2_SUC, l2_addrOK, l2_dataOK, busy;
  logic [31:0]   l2_addr, l2_wdata;
  logic [3:0]    l2_wstrb;
  logic [1:0]    l2_size;

  int checks = 0;
  int failures = 0;

  localparam logic [Lw-1:0] LinePat = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};

  always #5 clk = ~clk;

  l1_l2_port_arbiter #(.L1_offset_width(Ow)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_SUC(i_SUC), .i_addrOK(i_addrOK), .i_dataOK(i_dataOK),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_size(d_size), .d_SUC(d_SUC), .d_addrOK(d_addrOK), .d_dataOK(d_dataOK),
    .rdata(rdata), .l2_req(l2_req), .l2_wr(l2_wr), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_wstrb(l2_wstrb), .l2_size(l2_size), .l2_SUC(l2_SUC), .l2_addrOK(l2_addrOK),
    .l2_dataOK(l2_dataOK), .l2_rdata(l2_rdata), .busy(busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    i_req = 0; i_addr = 0; i_SUC = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; d_size = 0; d_SUC = 0;
    l2_addrOK = 0; l2_dataOK = 0; l2_rdata = LinePat;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({l2_req, l2_wr, l2_addr, l2_wdata, l2_wstrb, l2_size, l2_SUC, busy} !== '0) begin
      failures++; $display("FAIL reset_l2_fields: got %h want 0",
        {l2_req, l2_wr, l2_addr, l2_wdata, l2_wstrb, l2_size, l2_SUC, busy});
    end
    checks++;
    if ({i_addrOK, i_dataOK, d_addrOK, d_dataOK} !== 4'b0 || rdata !== '0) begin
      failures++; $display("FAIL reset_handshake: got %b rdata=%h want 0",
        {i_addrOK, i_dataOK, d_addrOK, d_dataOK}, rdata);
    end
  endtask

  task automatic test_icache_read();
    do_reset();
    i_req = 1; i_addr = 32'h1C000040; i_SUC = 1;
    #1;
    checks++;
    if (l2_req !== 1'b0) begin failures++; $display("FAIL ird_idle_req: got %b want 0", l2_req); end
    tick(); #1;
    checks++;
    if (l2_req !== 1 || l2_addr !== 32'h1C000040 || l2_wr !== 0 || l2_SUC !== 1 || i_addrOK !== 0) begin
      failures++; $display("FAIL ird_addr: req=%b addr=%h wr=%b suc=%b aok=%b want 1 1c000040 0 1 0",
        l2_req, l2_addr, l2_wr, l2_SUC, i_addrOK);
    end
    tick(); l2_addrOK = 1; #1;
    checks++;
    if (i_addrOK !== 1 || d_addrOK !== 0 || l2_req !== 1) begin
      failures++; $display("FAIL ird_addrok: i=%b d=%b req=%b want 1 0 1", i_addrOK, d_addrOK, l2_req);
    end
    tick(); l2_addrOK = 0; i_req = 0; #1;
    checks++;
    if (i_addrOK !== 0 || l2_req !== 0 || busy !== 1 || i_dataOK !== 0) begin
      failures++; $display("FAIL ird_data_wait: aok=%b req=%b busy=%b dok=%b want 0 0 1 0",
        i_addrOK, l2_req, busy, i_dataOK);
    end
    tick();
    tick(); l2_dataOK = 1; #1;
    checks++;
    if (i_dataOK !== 1 || d_dataOK !== 0 || d_addrOK !== 0 || rdata !== LinePat) begin
      failures++; $display("FAIL ird_dataok: i=%b d=%b daok=%b rdata=%h want 1 0 0 %h",
        i_dataOK, d_dataOK, d_addrOK, rdata, LinePat);
    end
    tick(); l2_dataOK = 0; #1;
    checks++;
    if (i_dataOK !== 0 || busy !== 0 || rdata !== '0) begin
      failures++; $display("FAIL ird_done: dok=%b busy=%b rdata=%h want 0 0 0", i_dataOK, busy, rdata);
    end
  endtask

  task automatic test_both_from_reset();
    do_reset();
    i_req = 1; i_addr = 32'h00000100; d_req = 1; d_wr = 0; d_addr = 32'h00000200;
    tick(); l2_addrOK = 1; #1;
    checks++;
    if (l2_addr !== 32'h00000200 || d_addrOK !== 1 || i_addrOK !== 0) begin
      failures++; $display("FAIL both_first_d: addr=%h daok=%b iaok=%b want 00000200 1 0",
        l2_addr, d_addrOK, i_addrOK);
    end
    tick(); l2_addrOK = 0; d_req = 0; l2_dataOK = 1; #1;
    checks++;
    if (d_dataOK !== 1 || i_dataOK !== 0) begin
      failures++; $display("FAIL both_d_data: d=%b i=%b want 1 0", d_dataOK, i_dataOK);
    end
    tick(); l2_dataOK = 0; #1;
    checks++;
    if (busy !== 0 || l2_req !== 0) begin
      failures++; $display("FAIL both_bubble: busy=%b req=%b want 0 0", busy, l2_req);
    end
    tick(); #1;
    checks++;
    if (l2_req !== 1 || l2_addr !== 32'h00000100 || l2_wr !== 0) begin
      failures++; $display("FAIL both_then_i: req=%b addr=%h wr=%b want 1 00000100 0",
        l2_req, l2_addr, l2_wr);
    end
    l2_addrOK = 1;
    tick(); l2_addrOK = 0; i_req = 0; l2_dataOK = 1;
    tick(); l2_dataOK = 0;
  endtask

  task automatic test_dcache_write();
    do_reset();
    d_req = 1; d_wr = 1; d_addr = 32'h00001000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    d_size = 2'b01; d_SUC = 1;
    tick();
    // Requester drops req and scribbles on its fields; the latched copy must hold.
    d_req = 0; d_wr = 0; d_addr = 32'hFFFFFFFF; d_wdata = 0; d_wstrb = 4'hF; d_size = 0; d_SUC = 0;
    #1;
    checks++;
    if (l2_req !== 1 || l2_wr !== 1 || l2_addr !== 32'h00001000 || l2_wdata !== 32'hDEADBEEF ||
        l2_wstrb !== 4'b0011 || l2_size !== 2'b01 || l2_SUC !== 1) begin
      failures++; $display("FAIL wr_fields: req=%b wr=%b addr=%h wd=%h st=%b sz=%b suc=%b",
        l2_req, l2_wr, l2_addr, l2_wdata, l2_wstrb, l2_size, l2_SUC);
    end
    tick(); #1;
    checks++;
    if (l2_req !== 1 || l2_addr !== 32'h00001000 || l2_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_held: req=%b addr=%h wd=%h want 1 00001000 deadbeef",
        l2_req, l2_addr, l2_wdata);
    end
    l2_addrOK = 1; #1;
    checks++;
    if (d_addrOK !== 1 || i_addrOK !== 0) begin
      failures++; $display("FAIL wr_addrok: d=%b i=%b want 1 0", d_addrOK, i_addrOK);
    end
    tick(); l2_addrOK = 0; #1;
    checks++;
    if (d_dataOK !== 0 || busy !== 1 || l2_req !== 0) begin
      failures++; $display("FAIL wr_wait: dok=%b busy=%b req=%b want 0 1 0", d_dataOK, busy, l2_req);
    end
    tick(); l2_dataOK = 1; #1;
    checks++;
    if (d_dataOK !== 1 || i_dataOK !== 0) begin
      failures++; $display("FAIL wr_done: d=%b i=%b want 1 0", d_dataOK, i_dataOK);
    end
    tick(); l2_dataOK = 0;
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    do_reset();
    i_req = 1; i_addr = 32'hAAAA0000; d_req = 1; d_wr = 0; d_addr = 32'hBBBB0000;
    for (int k = 0; k < 6; k++) begin
      exp_d = (k % 2 == 0);
      tick(); l2_addrOK = 1; #1;
      checks++;
      if (l2_addr !== (exp_d ? 32'hBBBB0000 : 32'hAAAA0000) || d_addrOK !== exp_d ||
          i_addrOK !== !exp_d) begin
        failures++; $display("FAIL rr_grant%0d: addr=%h daok=%b iaok=%b want_d=%b",
          k, l2_addr, d_addrOK, i_addrOK, exp_d);
      end
      tick(); l2_addrOK = 0; l2_dataOK = 1; #1;
      checks++;
      if (d_dataOK !== exp_d || i_dataOK !== !exp_d) begin
        failures++; $display("FAIL rr_data%0d: d=%b i=%b want_d=%b", k, d_dataOK, i_dataOK, exp_d);
      end
      tick(); l2_dataOK = 0; #1;
      checks++;
      if (busy !== 0) begin failures++; $display("FAIL rr_bubble%0d: busy=%b want 0", k, busy); end
    end
    i_req = 0; d_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_req = 1; i_addr = 32'h1C000040; i_SUC = 1;
    tick(); l2_addrOK = 1;
    tick(); l2_addrOK = 0; i_req = 0; #1;
    checks++;
    if (busy !== 1 || l2_req !== 0 || l2_addr !== 32'h1C000040) begin
      failures++; $display("FAIL rmid_in_data: busy=%b req=%b addr=%h want 1 0 1c000040",
        busy, l2_req, l2_addr);
    end
    rst = 1;
    tick(); rst = 0; #1;
    checks++;
    if ({busy, l2_req, l2_wr, l2_addr, l2_wdata, l2_wstrb, l2_size, l2_SUC} !== '0 ||
        rdata !== '0) begin
      failures++; $display("FAIL rmid_cleared: busy=%b addr=%h suc=%b rdata=%h want 0",
        busy, l2_addr, l2_SUC, rdata);
    end
    l2_dataOK = 1; #1;
    checks++;
    if ({i_dataOK, d_dataOK, i_addrOK, d_addrOK} !== 4'b0 || rdata !== '0) begin
      failures++; $display("FAIL rmid_late_dataok: hs=%b rdata=%h want 0",
        {i_dataOK, d_dataOK, i_addrOK, d_addrOK}, rdata);
    end
    tick(); l2_dataOK = 0;
  endtask

  task automatic test_spurious();
    do_reset();
    l2_dataOK = 1; l2_addrOK = 1; #1;
    checks++;
    if ({i_dataOK, d_dataOK, i_addrOK, d_addrOK} !== 4'b0 || busy !== 0) begin
      failures++; $display("FAIL sp_idle: hs=%b busy=%b want 0 0",
        {i_dataOK, d_dataOK, i_addrOK, d_addrOK}, busy);
    end
    tick(); l2_addrOK = 0; i_req = 1; i_addr = 32'h00000040; #1;
    checks++;
    if (busy !== 0) begin failures++; $display("FAIL sp_idle_stay: busy=%b want 0", busy); end
    tick(); #1;
    checks++;
    if (i_dataOK !== 0 || d_dataOK !== 0 || l2_req !== 1) begin
      failures++; $display("FAIL sp_addr_dataok: i=%b d=%b req=%b want 0 0 1", i_dataOK, d_dataOK, l2_req);
    end
    tick(); l2_addrOK = 1; #1;
    checks++;
    if (l2_req !== 1 || i_addrOK !== 1 || i_dataOK !== 0) begin
      failures++; $display("FAIL sp_both_in_addr: req=%b aok=%b dok=%b want 1 1 0",
        l2_req, i_addrOK, i_dataOK);
    end
    tick(); l2_dataOK = 0; i_req = 0; #1;
    checks++;
    if (i_addrOK !== 0 || l2_req !== 0 || busy !== 1) begin
      failures++; $display("FAIL sp_data_addrok: aok=%b req=%b busy=%b want 0 0 1", i_addrOK, l2_req, busy);
    end
    tick(); l2_addrOK = 0; #1;
    checks++;
    if (busy !== 1 || l2_req !== 0) begin
      failures++; $display("FAIL sp_still_data: busy=%b req=%b want 1 0", busy, l2_req);
    end
    l2_dataOK = 1; #1;
    checks++;
    if (i_dataOK !== 1) begin failures++; $display("FAIL sp_finish: dok=%b want 1", i_dataOK); end
    tick(); l2_dataOK = 0;
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_both_from_reset();
    test_dcache_write();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
